mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the CPU-side port of the three-block data memory. Grants one access per cycle to either requester 0 (scalar core) or requester 1 (vector load/store unit), using a valid/ready handshake. Decodes the 32-bit byte address into a block select and a 14-bit word address, and drives the per-block write enables. Returns read data one cycle later through a registered output-mux select, so the memory blocks themselves need no knowledge of the requesters.

## Interface
Parameters:
- NBLOCKS, 3, number of memory blocks behind the port (block index width 2)
- WORD_AW, 14, word address width per block
- DATA_W, 32, data width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  request valid, bit k = requester k
- req_ready  out  2  grant, bit k = requester k; combinational, at most one bit high
- req_we  in  2  1 = write, per requester
- req_addr0, req_addr1  in  32  byte address, per requester
- req_wdata0, req_wdata1  in  32  write data, per requester
- rsp_valid  out  2  response pulse, per requester
- rsp_err  out  1  response error flag, qualified by rsp_valid
- rsp_rdata  out  32  read data, qualified by rsp_valid
- mem_addr  out  14  word address to all blocks
- mem_wdata  out  32  write data to all blocks
- mem_wren  out  3  one-hot write enable per block
- mem_rdata0..mem_rdata2  in  32  synchronous-read data from each block; 1-cycle latency

## Operation
- Address decode:
  - word = addr[15:2]
  - block = addr[17:16]
  - addr[31:18] ignored.
- Error conditions: addr[1:0] ≠ 0 (misaligned), or block = 3 (unmapped). An errored access issues no write enable; its response carries rsp_err = 1 and rsp_rdata = 0.
- Grant:
  - One valid requester → granted.
  - Both valid → the requester not granted most recently wins (round-robin pointer `last`).
  - `last` updates only on a grant.
- Issue, cycle N (combinational from the granted request):
  - mem_addr = word
  - mem_wdata = wdata
  - mem_wren[block] = we & ~err
- When no request is granted: mem_addr = 0, mem_wdata = 0, mem_wren = 0.
- Response pipeline registers, loaded every cycle:
  - rsp_id_q (which requester)
  - rsp_v_q
  - sel_q (block)
  - err_q
  - we_q
- Response, cycle N+1:
  - rsp_valid[id] = 1 for exactly one cycle, for reads and writes alike (writes are acknowledged).
  - rsp_rdata = mem_rdata[sel_q] for a non-errored read; 0 for a write or an error.
- No response backpressure: requesters must sink rsp_valid.
- Requesters may hold req_valid across cycles. A new request can be granted every cycle: full throughput, back-to-back.
- State is limited to `last`, the response pipeline registers, and the lock state (see Configuration).

## Timing
- Reset values:
  - req_ready = 0 while rst is asserted
  - rsp_valid = 0
  - rsp_err = 0
  - rsp_rdata = 0
  - mem_wren = 0, mem_addr = 0, mem_wdata = 0
  - `last` = 1, so requester 0 wins the first tie
- Latency: grant to response is exactly 1 cycle. Throughput is 1 access per cycle.
- The handshake completes on a rising edge with req_valid[k] & req_ready[k].
- Simultaneous requests: the loser keeps req_ready = 0 and is granted on the next cycle if it is still valid.
- Reset mid-operation: a pending response is discarded. No rsp_valid is produced after reset deasserts for an access granted before reset.
- Same-block read-after-write on consecutive cycles: the read returns the memory's own read-during-write behaviour. The arbiter does not forward data.

## Configuration
- MEM_ARB_LOCK_EN: when defined, adds input `req_lock` (2 bits).
  - While the current owner k holds req_valid[k] & req_lock[k], it keeps the grant regardless of the other requester's request. This supports atomic read-modify-write and bursts.
  - Owner k releases by deasserting either bit. Round-robin then resumes with `last` = k.
  - The lock is cleared by reset and by an errored access.
- When MEM_ARB_LOCK_EN is undefined: no port, no lock state, pure round-robin.

## Test plan
- Reset, then only req 0 writes 0xDEADBEEF to 0x0001_0008 → in the grant cycle, mem_wren = 3'b010 and mem_addr = 2. Next cycle: rsp_valid = 2'b01, rsp_err = 0.
- Req 0 reads 0x0001_0008 → next cycle: rsp_rdata = 0xDEADBEEF from block 1, rsp_valid = 2'b01.
- Both requesters continuously valid for 6 cycles → grants alternate 0,1,0,1,0,1. Every cycle has exactly one rsp_valid bit set, one cycle after its grant.
- Req 1 reads 0x0003_0000 (block 3), then writes to 0x0000_0002 (misaligned) → mem_wren stays 0 for both. Each response has rsp_err = 1 and rsp_rdata = 0.
- Req 0 granted, then rst asserted on the following clock edge → rsp_valid = 0, mem_wren = 0. After reset deasserts, the first tie is granted to req 0.
- With MEM_ARB_LOCK_EN defined: req 0 holds req_lock[0] for 4 cycles while req 1 is valid → 4 grants go to req 0. Req 1 is granted in the cycle after the lock drops.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter and sequencer for the
// CPU-side port of the banked data memory. Decodes byte addresses into a
// block select plus word address, drives one-hot block write enables and
// returns read data one cycle later through a registered block select.
// Optional macro MEM_ARB_LOCK_EN adds a req_lock input that lets the current
// owner keep the port for atomic read-modify-write sequences and bursts.
module mem_port_arbiter #(
    parameter int NBLOCKS = 3,
    parameter int WORD_AW = 14,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_we,
    input  logic [31:0]        req_addr0,
    input  logic [31:0]        req_addr1,
    input  logic [DATA_W-1:0]  req_wdata0,
    input  logic [DATA_W-1:0]  req_wdata1,
`ifdef MEM_ARB_LOCK_EN
    input  logic [1:0]         req_lock,
`endif
    output logic [1:0]         rsp_valid,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic [WORD_AW-1:0] mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [NBLOCKS-1:0] mem_wren,
    input  logic [DATA_W-1:0]  mem_rdata0,
    input  logic [DATA_W-1:0]  mem_rdata1,
    input  logic [DATA_W-1:0]  mem_rdata2
);

    localparam logic [1:0] LAST_BLOCK = 2'(NBLOCKS - 1);

    logic              last_q, last_d;
    logic              rsp_v_q, rsp_v_d;
    logic              rsp_id_q, rsp_id_d;
    logic [1:0]        sel_q, sel_d;
    logic              err_q, err_d;
    logic              we_q, we_d;

    logic              grantAny;
    logic              grantId;
    logic              lockHold;
    logic [31:0]       selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              selWe;
    logic [1:0]        selBlock;
    logic              selErr;
    logic [DATA_W-1:0] rdataMux;
    logic              unusedAddrBits;

    // Upper address bits sit above the mapped region and carry no meaning here.
    assign unusedAddrBits = ^{req_addr0[31:WORD_AW+4], req_addr1[31:WORD_AW+4]};

`ifdef MEM_ARB_LOCK_EN
    logic lock_q, lock_d;

    // The previous owner keeps the port while it still asks with its lock bit set.
    assign lockHold = lock_q & req_valid[last_q] & req_lock[last_q];
`else
    assign lockHold = 1'b0;
`endif

    // Pick the granted requester: lock owner first, else round-robin on ties.
    always_comb begin
        grantAny = 1'b0;
        grantId  = 1'b0;
        if (!rst) begin
            if (lockHold) begin
                grantAny = 1'b1;
                grantId  = last_q;
            end else if (req_valid[0] && req_valid[1]) begin
                grantAny = 1'b1;
                grantId  = ~last_q;
            end else if (req_valid[0]) begin
                grantAny = 1'b1;
                grantId  = 1'b0;
            end else if (req_valid[1]) begin
                grantAny = 1'b1;
                grantId  = 1'b1;
            end
        end
    end

    // Route the granted request, decode it and drive the memory port.
    always_comb begin
        selAddr   = grantId ? req_addr1 : req_addr0;
        selWdata  = grantId ? req_wdata1 : req_wdata0;
        selWe     = req_we[grantId];
        selBlock  = selAddr[WORD_AW+3:WORD_AW+2];
        selErr    = (selAddr[1:0] != 2'b00) || (selBlock > LAST_BLOCK);
        req_ready = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = '0;
        if (grantAny) begin
            req_ready[grantId] = 1'b1;
            mem_addr           = selAddr[WORD_AW+1:2];
            mem_wdata          = selWdata;
            if (selWe && !selErr) begin
                mem_wren[selBlock] = 1'b1;
            end
        end
    end

    // Next-state values for the round-robin pointer and the response stage.
    always_comb begin
        last_d   = grantAny ? grantId : last_q;
        rsp_v_d  = grantAny;
        rsp_id_d = grantId;
        sel_d    = selBlock;
        err_d    = grantAny & selErr;
        we_d     = grantAny & selWe;
`ifdef MEM_ARB_LOCK_EN
        lock_d   = grantAny & req_lock[grantId] & ~selErr;
`endif
    end

    // State registers; reset drops any in-flight response and favours requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b1;
            rsp_v_q  <= 1'b0;
            rsp_id_q <= 1'b0;
            sel_q    <= 2'd0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            last_q   <= last_d;
            rsp_v_q  <= rsp_v_d;
            rsp_id_q <= rsp_id_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            we_q     <= we_d;
`ifdef MEM_ARB_LOCK_EN
            lock_q   <= lock_d;
`endif
        end
    end

    // Return the selected block's read data one cycle after the grant.
    always_comb begin
        case (sel_q)
            2'd0:    rdataMux = mem_rdata0;
            2'd1:    rdataMux = mem_rdata1;
            2'd2:    rdataMux = mem_rdata2;
            default: rdataMux = '0;
        endcase
        rsp_valid           = 2'b00;
        rsp_valid[rsp_id_q] = rsp_v_q;
        rsp_err             = rsp_v_q & err_q;
        rsp_rdata           = (rsp_v_q && !err_q && !we_q) ? rdataMux : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a small
// three-block synchronous-read memory model behind the port.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [1:0]  reqWe;
    logic [31:0] reqAddr0, reqAddr1;
    logic [31:0] reqWdata0, reqWdata1;
`ifdef MEM_ARB_LOCK_EN
    logic [1:0]  reqLock;
`endif
    logic [1:0]  rspValid;
    logic        rspErr;
    logic [31:0] rspRdata;
    logic [13:0] memAddr;
    logic [31:0] memWdata;
    logic [2:0]  memWren;
    logic [31:0] memRdata [3];
    logic [31:0] memBlock [3][16384];

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter dut (
        .clk(clk),
        .rst(rst),
        .req_valid(reqValid),
        .req_ready(reqReady),
        .req_we(reqWe),
        .req_addr0(reqAddr0),
        .req_addr1(reqAddr1),
        .req_wdata0(reqWdata0),
        .req_wdata1(reqWdata1),
`ifdef MEM_ARB_LOCK_EN
        .req_lock(reqLock),
`endif
        .rsp_valid(rspValid),
        .rsp_err(rspErr),
        .rsp_rdata(rspRdata),
        .mem_addr(memAddr),
        .mem_wdata(memWdata),
        .mem_wren(memWren),
        .mem_rdata0(memRdata[0]),
        .mem_rdata1(memRdata[1]),
        .mem_rdata2(memRdata[2])
    );

    always #5 clk = ~clk;

    // Synchronous-read memory blocks returning the old word on a same-cycle write.
    always @(posedge clk) begin
        for (int b = 0; b < 3; b++) begin
            if (memWren[b]) memBlock[b][memAddr] <= memWdata;
            memRdata[b] <= memBlock[b][memAddr];
        end
    end

    task automatic driveIdle();
        reqValid  = 2'b00;
        reqWe     = 2'b00;
        reqAddr0  = 32'h0;
        reqAddr1  = 32'h0;
        reqWdata0 = 32'h0;
        reqWdata1 = 32'h0;
`ifdef MEM_ARB_LOCK_EN
        reqLock   = 2'b00;
`endif
    endtask

    task automatic applyReset();
        @(negedge clk);
        driveIdle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqValid = 2'b11; reqWe = 2'b11;
        reqAddr0 = 32'h0001_0008; reqAddr1 = 32'h0002_0004;
        reqWdata0 = 32'h1111_1111; reqWdata1 = 32'h2222_2222;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (reqReady !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b expected 00", reqReady); end
        checks++; if (rspValid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 00", rspValid); end
        checks++; if (rspErr !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got %b expected 0", rspErr); end
        checks++; if (rspRdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata: got %h expected 0", rspRdata); end
        checks++; if (memWren !== 3'b000) begin failures++; $display("FAIL reset_wren: got %b expected 000", memWren); end
        checks++; if (memAddr !== 14'h0 || memWdata !== 32'h0) begin failures++; $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0 0", memAddr, memWdata); end
        @(negedge clk);
        driveIdle();
        rst = 1'b0;
    endtask

    task automatic test_write();
        @(negedge clk);
        reqValid = 2'b01; reqWe = 2'b01;
        reqAddr0 = 32'h0001_0008; reqWdata0 = 32'hDEAD_BEEF;
        #1;
        checks++; if (reqReady !== 2'b01) begin failures++; $display("FAIL write_ready: got %b expected 01", reqReady); end
        checks++; if (memWren !== 3'b010) begin failures++; $display("FAIL write_wren: got %b expected 010", memWren); end
        checks++; if (memAddr !== 14'd2) begin failures++; $display("FAIL write_addr: got %0d expected 2", memAddr); end
        checks++; if (memWdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL write_wdata: got %h expected deadbeef", memWdata); end
        @(posedge clk); #1;
        checks++; if (rspValid !== 2'b01) begin failures++; $display("FAIL write_rsp_valid: got %b expected 01", rspValid); end
        checks++; if (rspErr !== 1'b0 || rspRdata !== 32'h0) begin failures++; $display("FAIL write_rsp: got err %b rdata %h expected 0 0", rspErr, rspRdata); end
    endtask

    task automatic test_read();
        @(negedge clk);
        reqValid = 2'b01; reqWe = 2'b00; reqAddr0 = 32'h0001_0008;
        #1;
        checks++; if (reqReady !== 2'b01 || memWren !== 3'b000) begin failures++; $display("FAIL read_issue: got ready %b wren %b expected 01 000", reqReady, memWren); end
        @(posedge clk); #1;
        checks++; if (rspValid !== 2'b01) begin failures++; $display("FAIL read_rsp_valid: got %b expected 01", rspValid); end
        checks++; if (rspRdata !== 32'hDEAD_BEEF || rspErr !== 1'b0) begin failures++; $display("FAIL read_rdata: got %h err %b expected deadbeef 0", rspRdata, rspErr); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  expReady;
        logic [1:0]  prevReady;
        logic [31:0] expData;
        logic [31:0] prevData;
        applyReset();
        prevReady = 2'b00;
        prevData  = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                reqValid = 2'b11; reqWe = 2'b00;
                reqAddr0 = 32'h0000_0004; reqAddr1 = 32'h0002_0008;
            end
            #1;
            expReady = (i % 2 == 0) ? 2'b01 : 2'b10;
            expData  = (i % 2 == 0) ? 32'hB000_0001 : 32'hB020_0002;
            checks++; if (reqReady !== expReady) begin failures++; $display("FAIL rr_grant_%0d: got %b expected %b", i, reqReady, expReady); end
            if (i > 0) begin
                checks++; if (rspValid !== prevReady || rspRdata !== prevData) begin failures++; $display("FAIL rr_rsp_%0d: got valid %b rdata %h expected %b %h", i, rspValid, rspRdata, prevReady, prevData); end
            end
            prevReady = expReady;
            prevData  = expData;
        end
        @(negedge clk);
        driveIdle();
        #1;
        checks++; if (rspValid !== prevReady || rspRdata !== prevData) begin failures++; $display("FAIL rr_rsp_last: got valid %b rdata %h expected %b %h", rspValid, rspRdata, prevReady, prevData); end
        @(posedge clk); #1;
        checks++; if (rspValid !== 2'b00) begin failures++; $display("FAIL rr_rsp_idle: got %b expected 00", rspValid); end
    endtask

    task automatic test_errors();
        @(negedge clk);
        reqValid = 2'b10; reqWe = 2'b00; reqAddr1 = 32'h0003_0000;
        #1;
        checks++; if (reqReady !== 2'b10 || memWren !== 3'b000) begin failures++; $display("FAIL err_unmapped_issue: got ready %b wren %b expected 10 000", reqReady, memWren); end
        @(posedge clk); #1;
        checks++; if (rspValid !== 2'b10 || rspErr !== 1'b1 || rspRdata !== 32'h0) begin failures++; $display("FAIL err_unmapped_rsp: got valid %b err %b rdata %h expected 10 1 0", rspValid, rspErr, rspRdata); end
        @(negedge clk);
        reqWe = 2'b10; reqAddr1 = 32'h0000_0002; reqWdata1 = 32'h1234_5678;
        #1;
        checks++; if (reqReady !== 2'b10 || memWren !== 3'b000) begin failures++; $display("FAIL err_misaligned_issue: got ready %b wren %b expected 10 000", reqReady, memWren); end
        @(posedge clk); #1;
        checks++; if (rspValid !== 2'b10 || rspErr !== 1'b1 || rspRdata !== 32'h0) begin failures++; $display("FAIL err_misaligned_rsp: got valid %b err %b rdata %h expected 10 1 0", rspValid, rspErr, rspRdata); end
        @(negedge clk);
        driveIdle();
        reqValid = 2'b01; reqAddr0 = 32'h0001_0009;
        @(posedge clk); #1;
        checks++; if (rspValid !== 2'b01 || rspErr !== 1'b1 || rspRdata !== 32'h0) begin failures++; $display("FAIL err_misaligned_read: got valid %b err %b rdata %h expected 01 1 0", rspValid, rspErr, rspRdata); end
        @(negedge clk);
        driveIdle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reqValid = 2'b01; reqWe = 2'b01; reqAddr0 = 32'h0000_0010; reqWdata0 = 32'hCAFE_0001;
        #1;
        checks++; if (reqReady !== 2'b01) begin failures++; $display("FAIL rstmid_grant: got %b expected 01", reqReady); end
        @(posedge clk); #1;
        rst = 1'b1;
        reqValid = 2'b11; reqWe = 2'b00; reqAddr1 = 32'h0000_0020;
        #1;
        checks++; if (rspValid !== 2'b00 || memWren !== 3'b000 || reqReady !== 2'b00) begin failures++; $display("FAIL rstmid_flush: got valid %b wren %b ready %b expected 00 000 00", rspValid, memWren, reqReady); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (reqReady !== 2'b01) begin failures++; $display("FAIL rstmid_first_tie: got %b expected 01", reqReady); end
        checks++; if (rspValid !== 2'b00) begin failures++; $display("FAIL rstmid_no_stale: got %b expected 00", rspValid); end
        @(negedge clk);
        driveIdle();
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        applyReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                reqValid = 2'b11; reqWe = 2'b00; reqLock = 2'b01;
                reqAddr0 = 32'h0000_0004; reqAddr1 = 32'h0002_0008;
            end
            #1;
            checks++; if (reqReady !== 2'b01) begin failures++; $display("FAIL lock_hold_%0d: got %b expected 01", i, reqReady); end
        end
        @(negedge clk);
        reqLock = 2'b00;
        #1;
        checks++; if (reqReady !== 2'b10) begin failures++; $display("FAIL lock_release: got %b expected 10", reqReady); end
        @(negedge clk);
        driveIdle();
    endtask
`endif

    initial begin
        for (int b = 0; b < 3; b++) begin
            for (int w = 0; w < 16384; w++) begin
                memBlock[b][w] = 32'hB000_0000 | (32'(b) << 20) | 32'(w);
            end
        end
        driveIdle();
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_errors();
        test_reset_mid();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
